// File: rtl/note_tone_gen.sv
// note_tone_gen: dual phase-accumulator square-wave generator (note tone and beat clock).
// Each channel toggles its output whenever the accumulator wraps past CLK_HZ.
module note_tone_gen #(
  parameter int CLK_HZ = 50_000_000,
  parameter int FREQ_W = 24
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [FREQ_W-1:0] i_freq,
  input  logic [FREQ_W-1:0] i_beat_freq,
  output logic              o_pulse,
  output logic              o_beat,
  output logic              o_beat_tick
);
  localparam int AW = $clog2(CLK_HZ) + 2;
  localparam int SW = ((AW > FREQ_W + 1) ? AW : FREQ_W + 1) + 1;
  logic [1:0] w_q;
  logic       r_tick;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [FREQ_W-1:0] w_f;
    logic [SW-1:0]     w_step, w_sum;
    logic              w_sat, w_wrap, w_q_nxt;
    logic [AW-1:0]     w_acc_nxt, r_acc;
    logic              r_q;
    assign w_f       = (c == 0) ? i_freq : i_beat_freq;
    assign w_step    = SW'(w_f) << 1;
    assign w_sum     = SW'(r_acc) + w_step;
    assign w_sat     = w_step >= SW'(CLK_HZ);
    assign w_wrap    = w_sum >= SW'(CLK_HZ);
    // Saturated channels hold acc at 0 and toggle every cycle (CLK_HZ/2 output).
    assign w_acc_nxt = (w_f == '0 || w_sat) ? '0 :
                       w_wrap ? AW'(w_sum - SW'(CLK_HZ)) : AW'(w_sum);
    assign w_q_nxt   = (w_f == '0) ? 1'b0 : (w_sat || w_wrap) ? ~r_q : r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_acc <= '0;
        r_q   <= 1'b0;
      end else begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
      end
    end
    assign w_q[c] = r_q;
    if (c == 1) begin : g_tick
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_tick <= 1'b0;
        else          r_tick <= w_q_nxt & ~r_q;
      end
    end
  end
  assign o_pulse     = w_q[0];
  assign o_beat      = w_q[1];
  assign o_beat_tick = r_tick;
endmodule

// File: tb/tb_note_tone_gen.sv
// tb_note_tone_gen: directed vector table plus multi-cycle sequences at CLK_HZ=1000.
module tb_note_tone_gen;
  logic        clk, rst_n, pulse, beat, tick;
  logic [23:0] freq, beat_freq;
  int total, bad;

  note_tone_gen #(.CLK_HZ(1000), .FREQ_W(24)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_freq(freq), .i_beat_freq(beat_freq),
    .o_pulse(pulse), .o_beat(beat), .o_beat_tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] f;
    logic [23:0] b;
    int          n;
    logic        p, bt, tk;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [23:0] f, input logic [23:0] b);
    rst_n = 1'b0;
    freq = f;
    beat_freq = b;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int rises, ticks, bad_hp, tick_err, last, first, cnt, hi;
    logic prev, prev_b;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    freq = '0;
    beat_freq = '0;
    tbl[0]  = '{100, 0, 4,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{100, 0, 1,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{100, 0, 4,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{100, 0, 1,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{100, 0, 5,  1'b1, 1'b0, 1'b0};
    tbl[5]  = '{0,   0, 1,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{0,   0, 7,  1'b0, 1'b0, 1'b0};
    tbl[7]  = '{100, 0, 4,  1'b0, 1'b0, 1'b0};
    tbl[8]  = '{100, 0, 1,  1'b1, 1'b0, 1'b0};
    tbl[9]  = '{600, 0, 1,  1'b0, 1'b0, 1'b0};
    tbl[10] = '{600, 0, 1,  1'b1, 1'b0, 1'b0};
    tbl[11] = '{600, 0, 1,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{0,   0, 1,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{0,   8, 62, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{0,   8, 1,  1'b0, 1'b1, 1'b1};
    tbl[15] = '{0,   8, 1,  1'b0, 1'b1, 1'b0};
    #3;
    chk("reset pulse", int'(pulse), 0);
    chk("reset beat", int'(beat), 0);
    chk("reset tick", int'(tick), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      freq = tbl[i].f;
      beat_freq = tbl[i].b;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      chk($sformatf("row%0d pulse", i), int'(pulse), int'(tbl[i].p));
      chk($sformatf("row%0d beat", i), int'(beat), int'(tbl[i].bt));
      chk($sformatf("row%0d tick", i), int'(tick), int'(tbl[i].tk));
    end
    // Asynchronous reset while the note output is high.
    restart(100, 0);
    repeat (5) step();
    chk("pre-reset pulse", int'(pulse), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset pulse", int'(pulse), 0);
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt++;
      if (pulse) break;
    end
    chk("first rise after re-release", cnt, 5);
    // F=3: 9 rises in 3000 cycles, half-periods 166/167.
    restart(3, 0);
    rises = 0; bad_hp = 0; last = 0; first = 0; prev = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      step();
      if (pulse !== prev) begin
        if (last != 0 && (i - last < 166 || i - last > 167)) bad_hp++;
        if (last == 0) first = i;
        last = i;
        if (pulse) rises++;
      end
      prev = pulse;
    end
    chk("f3 rises", rises, 9);
    chk("f3 first toggle edge", first, 167);
    chk("f3 bad half-periods", bad_hp, 0);
    // Beat 8: 8 rises in 1000 cycles, half-periods 62/63, tick exactly on rises.
    restart(0, 8);
    rises = 0; ticks = 0; bad_hp = 0; tick_err = 0; last = 0; hi = 0; prev_b = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (tick !== (beat & ~prev_b)) tick_err++;
      if (tick) ticks++;
      if (pulse) hi++;
      if (beat !== prev_b) begin
        if (last != 0 && (i - last < 62 || i - last > 63)) bad_hp++;
        last = i;
        if (beat) rises++;
      end
      prev_b = beat;
    end
    chk("beat rises", rises, 8);
    chk("beat ticks", ticks, 8);
    chk("beat tick misplaced", tick_err, 0);
    chk("beat bad half-periods", bad_hp, 0);
    chk("silent pulse high cycles", hi, 0);
    // Saturated: toggles from the first edge after release.
    restart(600, 0);
    cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pulse !== logic'(i % 2)) cnt++;
    end
    chk("saturated toggle errors", cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Dual programmable square-wave generator for the arcade audio path: converts a note frequency in Hz into a speaker drive square wave (`o_pulse`) and a beat rate into a sequencer clock (`o_beat`, plus a one-cycle `o_beat_tick`). It sits between the song sequencer, which supplies note and beat frequencies, and the speaker pin. Both channels use identical phase-accumulator dividers, so arbitrary integer frequencies are produced with no hardware divider.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz; constant, must be even and > 2.
- `FREQ_W`, default 24: width of the frequency inputs.
- `i_clk`  in  1  system clock; all logic on its rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_freq`  in  FREQ_W  note frequency in Hz, unsigned; 0 means silence.
- `i_beat_freq`  in  FREQ_W  beat rate in Hz, unsigned; 0 stops the beat.
- `o_pulse`  out  1  note square wave, registered.
- `o_beat`  out  1  beat square wave, registered.
- `o_beat_tick`  out  1  one-cycle strobe, high on the cycle `o_beat` rises, registered.

## Operation
- Each channel has an accumulator `acc` of width ceil(log2(CLK_HZ)) + 2 bits and an output flop `q`.
- Each cycle with freq F ≠ 0:
  - `s = acc + 2*F`, computed at full width with no overflow.
  - If `s >= CLK_HZ`, then `acc <= s - CLK_HZ` and `q` toggles.
  - Otherwise `acc <= s`.
- If `2*F >= CLK_HZ`, the channel saturates: `q` toggles every cycle, `acc` is held at 0, and the output is CLK_HZ/2.
- Average output frequency is exactly F Hz. The half-period is floor or ceil of CLK_HZ/(2F) cycles, with long-term jitter of at most 1 cycle.
- F = 0: on the next edge `acc <= 0` and `q <= 0`. The output stays low until F becomes nonzero.
- A change of F takes effect on the next edge. `acc` and `q` are not cleared (phase-continuous), except on a change to 0.
- Inputs are sampled every cycle, with no handshake. The sequencer changes them at will and must drive them synchronously to `i_clk`.
- `o_beat_tick` is 1 for exactly the cycle in which `o_beat` is 1 and was 0 in the previous cycle.
- The two channels are fully independent.

## Timing
- Reset (`i_rst_n` = 0, asynchronous): both `acc` = 0, `o_pulse` = 0, `o_beat` = 0, `o_beat_tick` = 0. Reset applied mid-waveform clears the outputs immediately.
- After reset release, with constant F ≠ 0 (non-saturated), the first toggle (rising) occurs on edge number ceil(CLK_HZ/(2F)) after release.
- Latency from input change to effect: 1 cycle. All outputs come directly from flops, with no combinational path from the inputs.
- Saturated case: the output toggles on every edge starting with the first edge after release.

## Test plan
- CLK_HZ=1000, i_freq=100, release reset:
  - `o_pulse` rises on edge 5 and falls on edge 10.
  - Period is a steady 10 cycles with 50 % duty.
- CLK_HZ=1000, i_freq=3:
  - Over 3000 cycles exactly 9 rising edges.
  - Every half-period is 166 or 167 cycles.
- CLK_HZ=1000, i_beat_freq=8:
  - `o_beat` period is 125 cycles on average, with half-periods of 62 or 63 cycles.
  - `o_beat_tick` pulses exactly once per period, in the cycle `o_beat` rises, and is never high for 2 consecutive cycles.
- i_freq=100 running, then set to 0:
  - `o_pulse` is 0 from the next edge and stays 0.
  - After returning to 100, the first rise comes 5 cycles later.
- Reset asserted mid-waveform while `o_pulse`=1:
  - Outputs go to 0 without waiting for a clock edge.
  - After release, the behaviour matches the first scenario.
- CLK_HZ=1000, i_freq=600 (saturated): `o_pulse` toggles every cycle.
